// File: rtl/bypass_history.sv
// Operand bypass with a shift-register history of recent writeback packets.
// Returns the youngest matching bypass value or the register-file value; the result is registered.
module bypass_history #(
    parameter int ISSUE_WIDTH = 4,
    parameter int DEPTH       = 2,
    parameter int NUM_SRC     = 2,
    parameter int TAG_W       = 7,
    parameter int DATA_W      = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush_i,
    input  logic [ISSUE_WIDTH-1:0]        byp_valid_i,
    input  logic [ISSUE_WIDTH*TAG_W-1:0]  byp_tag_i,
    input  logic [ISSUE_WIDTH*DATA_W-1:0] byp_data_i,
    input  logic [NUM_SRC-1:0]            src_valid_i,
    input  logic [NUM_SRC*TAG_W-1:0]      src_tag_i,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data_i,
    output logic [NUM_SRC*DATA_W-1:0]     data_o,
    output logic [NUM_SRC-1:0]            valid_o,
    output logic [NUM_SRC-1:0]            hit_o,
    output logic [NUM_SRC*3-1:0]          hit_stage_o,
    output logic                          conflict_o
);

    // With DEPTH = 0 one dummy history stage exists but is never loaded or read.
    localparam int HD   = (DEPTH > 0) ? DEPTH : 1;
    localparam int NSTG = DEPTH + 1;

    logic [ISSUE_WIDTH-1:0]        hist_valid_q [HD];
    logic [ISSUE_WIDTH-1:0]        hist_valid_d [HD];
    logic [ISSUE_WIDTH*TAG_W-1:0]  hist_tag_q   [HD];
    logic [ISSUE_WIDTH*TAG_W-1:0]  hist_tag_d   [HD];
    logic [ISSUE_WIDTH*DATA_W-1:0] hist_data_q  [HD];
    logic [ISSUE_WIDTH*DATA_W-1:0] hist_data_d  [HD];

    logic [ISSUE_WIDTH-1:0]        stg_valid [NSTG];
    logic [ISSUE_WIDTH*TAG_W-1:0]  stg_tag   [NSTG];
    logic [ISSUE_WIDTH*DATA_W-1:0] stg_data  [NSTG];

    logic [DATA_W-1:0] sel_data  [NUM_SRC];
    logic [2:0]        sel_stage [NUM_SRC];
    logic [NUM_SRC-1:0] sel_hit;
    logic              conflict_set;
    logic              stage_hit;
    logic              stage_multi;
    logic [DATA_W-1:0] stage_data;

    logic [NUM_SRC*DATA_W-1:0] data_q, data_d;
    logic [NUM_SRC-1:0]        valid_q, valid_d;
    logic [NUM_SRC-1:0]        hit_q, hit_d;
    logic [NUM_SRC*3-1:0]      hit_stage_q, hit_stage_d;
    logic                      conflict_q, conflict_d;

    // Stage 0 is the live bypass bus; stage d is the packet from d cycles ago.
    always_comb begin
        stg_valid[0] = byp_valid_i;
        stg_tag[0]   = byp_tag_i;
        stg_data[0]  = byp_data_i;
        for (int d = 1; d < NSTG; d++) begin
            stg_valid[d] = hist_valid_q[d-1];
            stg_tag[d]   = hist_tag_q[d-1];
            stg_data[d]  = hist_data_q[d-1];
        end
    end

    always_comb begin
        for (int d = 0; d < HD; d++) begin
            hist_valid_d[d] = '0;
            hist_tag_d[d]   = hist_tag_q[d];
            hist_data_d[d]  = hist_data_q[d];
        end
        if (DEPTH > 0 && !flush_i) begin
            hist_valid_d[0] = byp_valid_i;
            hist_tag_d[0]   = byp_tag_i;
            hist_data_d[0]  = byp_data_i;
            for (int d = 1; d < HD; d++) begin
                hist_valid_d[d] = hist_valid_q[d-1];
                hist_tag_d[d]   = hist_tag_q[d-1];
                hist_data_d[d]  = hist_data_q[d-1];
            end
        end
    end

    // Walk stages oldest to youngest so a younger match overwrites an older one;
    // within a stage the first (lowest) matching lane is kept.
    always_comb begin
        conflict_set = 1'b0;
        stage_hit    = 1'b0;
        stage_multi  = 1'b0;
        stage_data   = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            sel_hit[s]   = 1'b0;
            sel_stage[s] = 3'd0;
            sel_data[s]  = src_data_i[s*DATA_W +: DATA_W];
            for (int d = NSTG - 1; d >= 0; d--) begin
                stage_hit   = 1'b0;
                stage_multi = 1'b0;
                stage_data  = '0;
                for (int k = 0; k < ISSUE_WIDTH; k++) begin
                    if (stg_valid[d][k] &&
                        stg_tag[d][k*TAG_W +: TAG_W] == src_tag_i[s*TAG_W +: TAG_W]) begin
                        if (stage_hit) begin
                            stage_multi = 1'b1;
                        end else begin
                            stage_hit  = 1'b1;
                            stage_data = stg_data[d][k*DATA_W +: DATA_W];
                        end
                    end
                end
                if (stage_hit) begin
                    sel_hit[s]   = 1'b1;
                    sel_stage[s] = 3'(d);
                    sel_data[s]  = stage_data;
                end
                if (stage_multi && src_valid_i[s]) begin
                    conflict_set = 1'b1;
                end
            end
        end
    end

    // Idle or flushed sources hold their last data and stage; flush beats a new conflict.
    always_comb begin
        valid_d     = flush_i ? '0 : src_valid_i;
        hit_d       = '0;
        data_d      = data_q;
        hit_stage_d = hit_stage_q;
        conflict_d  = flush_i ? 1'b0 : (conflict_q | conflict_set);
        for (int s = 0; s < NUM_SRC; s++) begin
            if (!flush_i && src_valid_i[s]) begin
                hit_d[s]                    = sel_hit[s];
                data_d[s*DATA_W +: DATA_W]  = sel_data[s];
                hit_stage_d[s*3 +: 3]       = sel_stage[s];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < HD; d++) begin
                hist_valid_q[d] <= '0;
            end
            data_q      <= '0;
            valid_q     <= '0;
            hit_q       <= '0;
            hit_stage_q <= '0;
            conflict_q  <= 1'b0;
        end else begin
            for (int d = 0; d < HD; d++) begin
                hist_valid_q[d] <= hist_valid_d[d];
            end
            data_q      <= data_d;
            valid_q     <= valid_d;
            hit_q       <= hit_d;
            hit_stage_q <= hit_stage_d;
            conflict_q  <= conflict_d;
        end
    end

    // History payload is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int d = 0; d < HD; d++) begin
            hist_tag_q[d]  <= hist_tag_d[d];
            hist_data_q[d] <= hist_data_d[d];
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign hit_o       = hit_q;
    assign hit_stage_o = hit_stage_q;
    assign conflict_o  = conflict_q;

endmodule
